// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are combinational; writes and scoreboard updates happen on posedge clk.
module regfile_sb #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned REG_NUM_BIT = 5,
  parameter int unsigned NR_READ     = 2,
  parameter int unsigned NR_WRITE    = 2,
  parameter int unsigned BYPASS      = 1,
  parameter int unsigned ZERO_REG    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NR_READ*REG_NUM_BIT-1:0]  raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]   rdata,
  output logic [NR_READ-1:0]              rbusy,
  input  logic [NR_WRITE*REG_NUM_BIT-1:0] waddr,
  input  logic [NR_WRITE*DATA_WIDTH-1:0]  wdata,
  input  logic [NR_WRITE-1:0]             wen,
  input  logic                            alloc_en,
  input  logic [REG_NUM_BIT-1:0]          alloc_addr,
  output logic                            alloc_ready,
  output logic [REG_NUM-1:0]              busy_vec,
  input  logic [REG_NUM_BIT-1:0]          dbg_addr,
  output logic [DATA_WIDTH-1:0]           dbg_data
);

  typedef logic [REG_NUM_BIT-1:0] addr_t;

  logic [DATA_WIDTH-1:0] rf_q [REG_NUM];
  logic [DATA_WIDTH-1:0] rf_d [REG_NUM];
  logic [REG_NUM-1:0]    busy_q, busy_d;
  logic [REG_NUM-1:0]    clear;
  logic [NR_WRITE-1:0]   whit [REG_NUM];

  // Register 0 is excluded from every lookup when hardwired to zero.
  function automatic logic hard_zero(input int unsigned r);
    return (ZERO_REG != 0) && (r == 0);
  endfunction

  // Per-register, per-port write hits; addresses >= REG_NUM never match.
  always_comb begin
    whit  = '{default: '0};
    clear = '0;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      for (int unsigned j = 0; j < NR_WRITE; j++) begin
        whit[r][j] = wen[j] && (waddr[j*REG_NUM_BIT +: REG_NUM_BIT] == addr_t'(r))
                     && !hard_zero(r);
      end
      clear[r] = |whit[r];
    end
  end

  always_comb begin
    rf_d = rf_q;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      for (int unsigned j = 0; j < NR_WRITE; j++) begin
        if (whit[r][j]) rf_d[r] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NR_READ; i++) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        if ((raddr[i*REG_NUM_BIT +: REG_NUM_BIT] == addr_t'(r)) && !hard_zero(r)) begin
          rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[r];
          rbusy[i]                          = busy_q[r];
          if (BYPASS != 0) begin
            for (int unsigned j = 0; j < NR_WRITE; j++) begin
              if (whit[r][j]) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
                rbusy[i]                          = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // A same-cycle writeback frees the register for a new allocation.
  always_comb begin
    alloc_ready = 1'b1;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      if ((alloc_addr == addr_t'(r)) && !hard_zero(r)) begin
        alloc_ready = ~busy_q[r] | clear[r];
      end
    end
  end

  // Allocation overrides a same-cycle clear.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      if (clear[r]) busy_d[r] = 1'b0;
      if (alloc_en && alloc_ready && (alloc_addr == addr_t'(r)) && !hard_zero(r)) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_comb begin
    dbg_data = '0;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      if (dbg_addr == addr_t'(r)) dbg_data = rf_q[r];
    end
  end

  assign busy_vec = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < REG_NUM; r++) rf_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < REG_NUM; r++) rf_q[r] <= rf_d[r];
      busy_q <= busy_d;
    end
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port integer register file for the npc core, with a per-register busy scoreboard.
- Successor to the single-write, two-read, reset-less register file.
- Adds:
  - configurable read and write port counts,
  - asynchronous reset of the whole array,
  - optional same-cycle write-to-read bypass,
  - a busy bit per register, so decode can stall on pending writebacks.

Parameters:
- DATA_WIDTH, 32, bits per register
- REG_NUM, 32, number of architectural registers
- REG_NUM_BIT, 5, address width; must satisfy 2**REG_NUM_BIT >= REG_NUM
- NR_READ, 2, number of read ports
- NR_WRITE, 2, number of write ports
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = return stored data only
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NR_READ*REG_NUM_BIT  read addresses; port i is at slice [i*REG_NUM_BIT +: REG_NUM_BIT].
- rdata  out  NR_READ*DATA_WIDTH  read data, packed the same way.
- rbusy  out  NR_READ  busy flag for each read address.
- waddr  in  NR_WRITE*REG_NUM_BIT  write addresses.
- wdata  in  NR_WRITE*DATA_WIDTH  write data.
- wen  in  NR_WRITE  per-port write enable; a write also clears the busy bit.
- alloc_en  in  1  request to mark alloc_addr busy (a destination is issued).
- alloc_addr  in  REG_NUM_BIT  register to allocate.
- alloc_ready  out  1  allocation is accepted this cycle.
- busy_vec  out  REG_NUM  full scoreboard, registered.
- dbg_addr  in  REG_NUM_BIT  debug/difftest read address.
- dbg_data  out  DATA_WIDTH  stored value at dbg_addr; never bypassed.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - all registers go to 0 and all busy bits go to 0;
  - hence rdata=0, rbusy=0, busy_vec=0, dbg_data=0, alloc_ready=1.
- Reset asserted mid-operation discards in-flight writes and allocations in that cycle.
- Writes:
  - posedge, for every port j with wen[j]=1: rf[waddr_j] <= wdata_j.
  - Several ports targeting the same address in one cycle: the highest port index wins.
  - waddr >= REG_NUM is ignored.
  - With ZERO_REG=1, writes to register 0 are dropped.
- Reads (combinational, zero latency):
  - ZERO_REG=1 and raddr=0 -> rdata=0, rbusy=0.
  - raddr >= REG_NUM -> rdata=0, rbusy=0.
  - BYPASS=1 and some wen[j] with waddr_j==raddr (and not a dropped zero-register write): rdata = wdata of the highest matching j, rbusy=0.
  - Otherwise: rdata=rf[raddr], rbusy=busy[raddr].
  - BYPASS=0: rdata=rf[raddr] and rbusy=busy[raddr]; write data becomes visible the cycle after the write.
- Scoreboard:
  - clear_r = (some wen[j] with waddr_j==r, r valid and not a dropped zero-register write).
  - alloc_ready = ~(ZERO_REG && alloc_addr==0) ? (~busy[alloc_addr] | clear_alloc_addr) : 1.
  - alloc_ready is combinational; alloc_addr >= REG_NUM gives alloc_ready=1 with no effect.
  - Posedge: busy[r] <= (alloc_en & alloc_ready & alloc_addr==r) ? 1 : (clear_r ? 0 : busy[r]).
  - Simultaneous allocation and writeback on the same register: allocation wins, busy stays 1, data is still written.
  - alloc_en while alloc_ready=0: ignored, no state change; the requester must hold and retry.
  - Allocating register 0 with ZERO_REG=1: accepted, no effect.
  - A write to a non-busy register is legal; busy stays 0.
- busy_vec is a direct copy of the busy registers. Bit 0 is 0 when ZERO_REG=1; bits >= REG_NUM do not exist.
- Data has no arithmetic; all widths are exact and there is no wrap-around behaviour.
- The block contains no $display statements; tracing is done in the bench.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst mid-cycle -> immediately rdata(r5)=0, busy_vec=0, alloc_ready=1.
- Bypass:
  - BYPASS=1, wen0 writes r10=0x1234 with raddr0=10 in the same cycle -> rdata0=0x1234 that cycle.
  - BYPASS=0, same stimulus -> old value that cycle, 0x1234 the next.
- Write collision: wen0 r3=0xAAAA0000 and wen1 r3=0x5555FFFF in the same cycle -> next cycle rf[3]=0x5555FFFF, dbg_data(3)=0x5555FFFF.
- Zero register: write r0=0xFFFFFFFF and alloc r0 -> rdata(0)=0, rbusy=0, busy_vec[0]=0.
- Scoreboard:
  - alloc r7 -> busy_vec[7]=1 next cycle and rbusy=1 on read of r7.
  - A second alloc r7 -> alloc_ready=0, no change.
  - Writeback r7=0x42 -> busy_vec[7]=0 next cycle, rdata=0x42.
- Same-cycle alloc and writeback on r9 (busy) -> alloc_ready=1, rf[9] updated, busy_vec[9] stays 1.
